alu_addr_seq: RTL and testbench
===============================

Name: alu_addr_seq

Overview:
- Multi-cycle sequencer that borrows the shared 8-bit ALU to compute 16-bit effective addresses: indexed (base + unsigned index), relative branch (base + signed offset) and zero-page wrap.
- Runs a low-byte add cycle, then an optional high-byte INC/DEC/pass cycle, and reports page crossing and cycle count.
- Sits between the instruction decoder (request side) and the ALU ports, which the parent muxes to this block while `busy` is high.

Parameters:
- OPW, 6, ALU op field width. Must match the ALU op port.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  block can accept a request (IDLE only)
- req_mode  in  2  00 indexed unsigned, 01 relative signed, 10 zero-page wrap, 11 treated as 00
- req_base  in  16  base address
- req_off  in  8  index or signed offset
- req_force  in  1  always spend the high-byte cycle (stores/RMW)
- alu_op  out  OPW  op driven to the ALU
- alu_a  out  8  ALU port a
- alu_b  out  8  ALU port b
- alu_ci  out  1  ALU carry in
- alu_out  in  8  ALU result
- alu_status  in  8  ALU flags; bit0 = carry
- busy  out  1  high in LO and HI states
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts the result
- rsp_addr  out  16  effective address
- rsp_cross  out  1  page crossed
- rsp_cycles  out  2  ALU cycles used (1 or 2)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rsp_valid, rsp_addr, rsp_cross, rsp_cycles, busy = 0.
  - alu_op=ALU_NOP, alu_a=alu_b=0, alu_ci=0.
  - Reset mid-operation abandons the request; no response is issued.
- IDLE:
  - req_ready=1; ALU driven with NOP and zeros.
  - On req_valid&&req_ready: latch base, off, mode and force; go to LO.
- LO (one cycle):
  - Drive alu_op=ALU_ADD, alu_a=base[7:0], alu_b=off, alu_ci=0.
  - At the clock edge: lo<=alu_out; carry c=alu_status[0].
  - Adjust rule:
    - mode 00: inc=c.
    - mode 01: inc=c&!off[7]; dec=!c&off[7].
    - mode 10: no adjust; high byte forced to 0x00, cross=0, go to DONE.
  - cross=inc|dec.
  - If cross or force, go to HI; else hi=base[15:8] and go to DONE.
- HI (one cycle):
  - Drive alu_a=alu_b=base[15:8] (both ports, so unary ops see the operand), alu_ci=0.
  - alu_op = ALU_INC if inc, ALU_DEC if dec, otherwise ALU_NOP (pass).
  - hi<=alu_out; go to DONE.
- DONE:
  - rsp_valid=1; rsp_addr={hi,lo}; rsp_cross; rsp_cycles = 1 (no HI) or 2.
  - Hold all rsp fields stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE and clear rsp_valid.
  - A req_valid in the same cycle is not accepted; it is accepted next cycle in IDLE.
- Wrap-around:
  - High-byte INC of 0xFF gives 0x00; DEC of 0x00 gives 0xFF. 16-bit wrap, no error.
- Throughput: one request per 3 cycles minimum (IDLE→LO→DONE) when rsp_ready is tied high.
- Output timing: all rsp_* and busy are registered; ALU drive outputs are decoded from state.

Decomposition:
- Shared defs: ALU_ADD, ALU_INC, ALU_DEC, ALU_NOP op constants.
- New package entries:
  - addr_mode_t enum {AM_IDX, AM_REL, AM_ZP}.
  - aseq_state_t enum {IDLE, LO, HI, DONE}.
- No sub-module. The ALU is instantiated by the parent, not inside this block.

Test Plan:
1. Indexed with carry: mode00, base 0x12F0, off 0x20, force0 → LO drives ADD a=0xF0 b=0x20; HI drives INC a=b=0x12; rsp_addr 0x1310, cross1, cycles2.
2. Indexed without carry: mode00, base 0x1200, off 0x10, force0 → 0x1210, cross0, cycles1. Same with force1 → HI drives NOP; 0x1210, cross0, cycles2.
3. Relative:
   - base 0x3405, off 0xF0 → DEC → 0x33F5, cross1.
   - base 0x34F0, off 0x20 → INC → 0x3510, cross1.
   - base 0x3410, off 0xF0 → 0x3400, cross0, cycles1.
4. Zero-page: mode10, base 0x00F0, off 0x20 → 0x0010, cross0, cycles1, no HI cycle.
5. Backpressure and wrap: base 0xFFF0, off 0x20, rsp_ready low 5 cycles → rsp 0x0010 held stable, req_ready=0; then rsp_ready=1 → IDLE next cycle.
6. Reset mid-HI: assert rst_n=0 during HI → outputs 0 immediately (asynchronous); after release, a new request completes normally.

Source files
------------

// File: rtl/alu_addr_seq_pkg.sv
// Shared definitions for the effective-address sequencer: ALU op encodings,
// addressing modes and sequencer states.
package alu_addr_seq_pkg;

  // ALU op encodings; must agree with the shared ALU decoder.
  localparam logic [5:0] ALU_NOP = 6'h00;
  localparam logic [5:0] ALU_ADD = 6'h01;
  localparam logic [5:0] ALU_INC = 6'h08;
  localparam logic [5:0] ALU_DEC = 6'h09;

  typedef enum logic [1:0] {
    AM_IDX = 2'd0,
    AM_REL = 2'd1,
    AM_ZP  = 2'd2
  } addr_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } aseq_state_t;

  // Request mode 2'b11 is folded onto indexed addressing.
  function automatic addr_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return AM_REL;
      2'b10:   return AM_ZP;
      default: return AM_IDX;
    endcase
  endfunction

endpackage

// File: rtl/alu_addr_seq.sv
// Effective-address sequencer: borrows the shared 8-bit ALU for a low-byte add
// and an optional high-byte INC/DEC/pass, then reports address, crossing and cycle count.
module alu_addr_seq
  import alu_addr_seq_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [15:0]      req_base,
  input  logic [7:0]       req_off,
  input  logic             req_force,
  output logic [OPW-1:0]   alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_ci,
  input  logic [7:0]       alu_out,
  input  logic [7:0]       alu_status,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_addr,
  output logic             rsp_cross,
  output logic [1:0]       rsp_cycles
);

  aseq_state_t state_reg;
  addr_mode_t  mode_reg;
  logic [15:0] base_reg;
  logic [7:0]  off_reg;
  logic        force_reg;
  logic [7:0]  lo_reg;
  logic        inc_reg;
  logic        dec_reg;
  logic        busy_reg;
  logic        rsp_valid_reg;
  logic [15:0] rsp_addr_reg;
  logic        rsp_cross_reg;
  logic [1:0]  rsp_cycles_reg;

  logic        lo_carry;
  logic        inc_next;
  logic        dec_next;
  logic        unused_status;

  assign unused_status = ^alu_status[7:1];

  assign req_ready  = (state_reg == IDLE);
  assign busy       = busy_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_addr   = rsp_addr_reg;
  assign rsp_cross  = rsp_cross_reg;
  assign rsp_cycles = rsp_cycles_reg;

  // High-byte adjust derived from the low-byte carry; a negative relative
  // offset without carry borrows from the high byte.
  always_comb begin
    lo_carry = alu_status[0];
    inc_next = 1'b0;
    dec_next = 1'b0;
    case (mode_reg)
      AM_IDX: inc_next = lo_carry;
      AM_REL: begin
        inc_next = lo_carry & ~off_reg[7];
        dec_next = ~lo_carry & off_reg[7];
      end
      default: ;
    endcase
  end

  // ALU drive is a pure decode of state so the parent mux sees it immediately.
  always_comb begin
    alu_op = OPW'(ALU_NOP);
    alu_a  = 8'h00;
    alu_b  = 8'h00;
    alu_ci = 1'b0;
    case (state_reg)
      LO: begin
        alu_op = OPW'(ALU_ADD);
        alu_a  = base_reg[7:0];
        alu_b  = off_reg;
      end
      HI: begin
        alu_a = base_reg[15:8];
        alu_b = base_reg[15:8];
        if (inc_reg)      alu_op = OPW'(ALU_INC);
        else if (dec_reg) alu_op = OPW'(ALU_DEC);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      mode_reg       <= AM_IDX;
      base_reg       <= 16'h0000;
      off_reg        <= 8'h00;
      force_reg      <= 1'b0;
      lo_reg         <= 8'h00;
      inc_reg        <= 1'b0;
      dec_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_addr_reg   <= 16'h0000;
      rsp_cross_reg  <= 1'b0;
      rsp_cycles_reg <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            base_reg  <= req_base;
            off_reg   <= req_off;
            mode_reg  <= decode_mode(req_mode);
            force_reg <= req_force;
            busy_reg  <= 1'b1;
            state_reg <= LO;
          end
        end
        LO: begin
          lo_reg  <= alu_out;
          inc_reg <= inc_next;
          dec_reg <= dec_next;
          if (mode_reg == AM_ZP) begin
            rsp_addr_reg   <= {8'h00, alu_out};
            rsp_cross_reg  <= 1'b0;
            rsp_cycles_reg <= 2'd1;
            rsp_valid_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= DONE;
          end else if (inc_next || dec_next || force_reg) begin
            state_reg <= HI;
          end else begin
            rsp_addr_reg   <= {base_reg[15:8], alu_out};
            rsp_cross_reg  <= 1'b0;
            rsp_cycles_reg <= 2'd1;
            rsp_valid_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            state_reg      <= DONE;
          end
        end
        HI: begin
          rsp_addr_reg   <= {alu_out, lo_reg};
          rsp_cross_reg  <= inc_reg | dec_reg;
          rsp_cycles_reg <= 2'd2;
          rsp_valid_reg  <= 1'b1;
          busy_reg       <= 1'b0;
          state_reg      <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_addr_seq.sv
// Directed bench for alu_addr_seq with a small behavioural model of the shared ALU.
module tb_alu_addr_seq;
  import alu_addr_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [15:0] req_base;
  logic [7:0]  req_off;
  logic        req_force;
  logic [5:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_ci;
  logic [7:0]  alu_out;
  logic [7:0]  alu_status;
  logic        busy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_addr;
  logic        rsp_cross;
  logic [1:0]  rsp_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  alu_addr_seq #(.OPW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_base(req_base), .req_off(req_off), .req_force(req_force),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_status(alu_status),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_cross(rsp_cross), .rsp_cycles(rsp_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the parent's shared ALU.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum    = 9'h000;
    alu_out    = 8'h00;
    alu_status = 8'h00;
    case (alu_op)
      ALU_ADD: begin
        alu_sum       = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
        alu_out       = alu_sum[7:0];
        alu_status[0] = alu_sum[8];
      end
      ALU_INC: alu_out = alu_a + 8'h01;
      ALU_DEC: alu_out = alu_a - 8'h01;
      default: alu_out = alu_a;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request: checks LO drive, optional HI drive, then the DONE response.
  // When rsp_ready is high the return to IDLE is checked as well.
  task automatic run(input string tag, input logic [1:0] mode, input logic [15:0] base,
                     input logic [7:0] off, input logic frc, input logic do_hi,
                     input logic [5:0] hi_op, input logic [15:0] exp_addr,
                     input logic exp_cross, input logic [1:0] exp_cyc);
    check({tag, " req_ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_mode = mode; req_base = base; req_off = off; req_force = frc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, " lo_op"}, 32'(alu_op), 32'(ALU_ADD));
    check({tag, " lo_ab"}, {15'h0, alu_ci, alu_a, alu_b}, {15'h0, 1'b0, base[7:0], off});
    check({tag, " lo_busy"}, 32'(busy), 32'h1);
    if (do_hi) begin
      @(posedge clk); #1;
      check({tag, " hi_op"}, 32'(alu_op), 32'(hi_op));
      check({tag, " hi_ab"}, {15'h0, alu_ci, alu_a, alu_b}, {15'h0, 1'b0, base[15:8], base[15:8]});
    end
    @(posedge clk); #1;
    check({tag, " valid"}, {busy, req_ready, rsp_valid}, 3'b001);
    check({tag, " addr"}, 32'(rsp_addr), 32'(exp_addr));
    check({tag, " cross_cyc"}, {rsp_cross, rsp_cycles}, {exp_cross, exp_cyc});
    if (rsp_ready) begin
      @(posedge clk); #1;
      check({tag, " back_idle"}, {req_ready, rsp_valid, busy}, 3'b100);
    end
    $display("[TB] %s mode=%0d base=%h off=%h force=%0d -> addr=%h cross=%0d cycles=%0d",
             tag, mode, base, off, frc, rsp_addr, rsp_cross, rsp_cycles);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_mode = 2'b00; req_base = 16'h0;
    req_off = 8'h0; req_force = 1'b0; rsp_ready = 1'b1;
    #2;
    check("reset_rsp", {15'h0, rsp_valid, rsp_addr}, 32'h0);
    check("reset_misc", {26'h0, busy, rsp_cross, rsp_cycles, req_ready, 1'b0}, 32'h2);
    check("reset_alu", {7'h0, alu_op, alu_a, alu_b, alu_ci}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("idx_carry",   2'b00, 16'h12F0, 8'h20, 1'b0, 1'b1, ALU_INC, 16'h1310, 1'b1, 2'd2);
    run("idx_nocarry", 2'b00, 16'h1200, 8'h10, 1'b0, 1'b0, ALU_NOP, 16'h1210, 1'b0, 2'd1);
    run("idx_force",   2'b00, 16'h1200, 8'h10, 1'b1, 1'b1, ALU_NOP, 16'h1210, 1'b0, 2'd2);
    run("rel_dec",     2'b01, 16'h3405, 8'hF0, 1'b0, 1'b1, ALU_DEC, 16'h33F5, 1'b1, 2'd2);
    run("rel_inc",     2'b01, 16'h34F0, 8'h20, 1'b0, 1'b1, ALU_INC, 16'h3510, 1'b1, 2'd2);
    run("rel_same",    2'b01, 16'h3410, 8'hF0, 1'b0, 1'b0, ALU_NOP, 16'h3400, 1'b0, 2'd1);
    run("rel_wrap",    2'b01, 16'h0005, 8'hF0, 1'b0, 1'b1, ALU_DEC, 16'hFFF5, 1'b1, 2'd2);
    run("zp_wrap",     2'b10, 16'h00F0, 8'h20, 1'b0, 1'b0, ALU_NOP, 16'h0010, 1'b0, 2'd1);
    run("zp_force",    2'b10, 16'h1280, 8'h05, 1'b1, 1'b0, ALU_NOP, 16'h0085, 1'b0, 2'd1);
    run("mode11",      2'b11, 16'h12F0, 8'h20, 1'b0, 1'b1, ALU_INC, 16'h1310, 1'b1, 2'd2);

    // Backpressure with 16-bit wrap.
    rsp_ready = 1'b0;
    run("bp_wrap",     2'b00, 16'hFFF0, 8'h20, 1'b0, 1'b1, ALU_INC, 16'h0010, 1'b1, 2'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {req_ready, rsp_valid, rsp_cross, rsp_cycles, rsp_addr},
            {1'b0, 1'b1, 1'b1, 2'd2, 16'h0010});
      $display("[TB] bp_hold cycle=%0d addr=%h valid=%0d", i, rsp_addr, rsp_valid);
    end
    // Handshake cycle: a simultaneous request must wait for IDLE.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_mode = 2'b00; req_base = 16'h1200; req_off = 8'h10; req_force = 1'b0;
    @(posedge clk); #1;
    check("bp_release", {req_ready, rsp_valid, busy}, 3'b100);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_next_lo", {busy, alu_a, alu_b}, {1'b1, 8'h00, 8'h10});
    @(posedge clk); #1;
    check("bp_next_addr", {rsp_valid, rsp_addr}, {1'b1, 16'h1210});
    @(posedge clk); #1;
    $display("[TB] bp_next addr=1210 accepted after handshake");

    // Asynchronous reset while in HI.
    req_valid = 1'b1; req_mode = 2'b00; req_base = 16'h12F0; req_off = 8'h20; req_force = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_hi", {busy, alu_op}, {1'b1, ALU_INC});
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {7'h0, busy, rsp_valid, alu_op, alu_a, alu_b, alu_ci}, 32'h0);
    check("rst_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_no_rsp", {rsp_valid, busy}, 2'b00);
    $display("[TB] reset mid-HI abandoned request");
    run("post_reset",  2'b01, 16'h34F0, 8'h20, 1'b0, 1'b1, ALU_INC, 16'h3510, 1'b1, 2'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
